// File: rtl/fxp_pkg.sv
// Shared opcodes, FSM state type and the saturating clamp for the fixed-point ALU.
package fxp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest intermediate the clamp accepts; callers sign-extend into it.
  localparam int unsigned SAT_MAXW = 128;

  typedef struct packed {
    logic                ovf;
    logic [SAT_MAXW-1:0] val;
  } sat_t;

  // Clamp a signed value to the w-bit two's-complement range; ovf flags clamping.
  function automatic sat_t sat(input logic signed [SAT_MAXW-1:0] value, input int unsigned w);
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    sat_t r;
    hi = (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
    lo = ~hi;
    r.ovf = 1'b1;
    if (value > hi) begin
      r.val = hi;
    end else if (value < lo) begin
      r.val = lo;
    end else begin
      r.val = value;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle; the start cycle retires the first bit.
module fxp_div_iter #(
  parameter int unsigned WN = 40,
  parameter int unsigned WD = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [WN-1:0] dividend_i,
  input  logic [WD-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [WN-1:0] quot_o
);

  localparam int unsigned CW = $clog2(WN + 1);

  logic [WN-1:0] quot_q, quot_d;
  logic [WD-1:0] rem_q, rem_d;
  logic [WD-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;

  logic [WN-1:0] src_quot_c;
  logic [WD-1:0] src_rem_c, src_div_c;
  logic [WD:0]   trial_c, diff_c;
  logic          fits_c;

  // One restoring step; on start it operates on the fresh operands.
  always_comb begin
    src_quot_c = start_i ? dividend_i : quot_q;
    src_rem_c  = start_i ? '0 : rem_q;
    src_div_c  = start_i ? divisor_i : div_q;
    trial_c    = {src_rem_c, src_quot_c[WN-1]};
    diff_c     = trial_c - {1'b0, src_div_c};
    fits_c     = ~diff_c[WD];
    rem_d      = fits_c ? diff_c[WD-1:0] : trial_c[WD-1:0];
    quot_d     = {src_quot_c[WN-2:0], fits_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      div_q  <= divisor_i;
      cnt_q  <= CW'(WN - 1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/fxp_alu.sv
// Handshaked saturating Q(IW).(FW) ALU: add/sub in one cycle, registered multiply,
// iterative divide; one operation outstanding at a time.
module fxp_alu
  import fxp_pkg::*;
#(
  parameter  int unsigned IW = 8,
  parameter  int unsigned FW = 16,
  localparam int unsigned W  = IW + FW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   aluop_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] result_o,
  output logic         ovf_o,
  output logic         dz_o
);

  localparam int unsigned QW = W + FW;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] result_q, result_d;
  logic         ovf_q, ovf_d, dz_q, dz_d, out_valid_q;

  logic          div_start_c, div_busy, div_done;
  logic [QW-1:0] div_quot;
  logic [W-1:0]  abs_a_c, abs_b_c;

  logic signed [W:0]     sum_c, dif_c;
  logic signed [2*W-1:0] prod_c, prod_sh_c;
  logic signed [QW:0]    quot_s_c;
  sat_t                  add_s, sub_s, mul_s, div_s;
  logic                  unused_sat_c;

  // Add/sub see the live operands so they finish on the accept edge.
  assign sum_c     = $signed({a_i[W-1], a_i}) + $signed({b_i[W-1], b_i});
  assign dif_c     = $signed({a_i[W-1], a_i}) - $signed({b_i[W-1], b_i});
  assign prod_c    = (2*W)'($signed(a_q)) * (2*W)'($signed(b_q));
  assign prod_sh_c = prod_c >>> FW;
  assign quot_s_c  = (a_q[W-1] ^ b_q[W-1]) ? -$signed({1'b0, div_quot}) : $signed({1'b0, div_quot});

  assign add_s = sat(SAT_MAXW'(sum_c), W);
  assign sub_s = sat(SAT_MAXW'(dif_c), W);
  assign mul_s = sat(SAT_MAXW'(prod_sh_c), W);
  assign div_s = sat(SAT_MAXW'(quot_s_c), W);

  assign unused_sat_c = ^{add_s.val[SAT_MAXW-1:W], sub_s.val[SAT_MAXW-1:W],
                          mul_s.val[SAT_MAXW-1:W], div_s.val[SAT_MAXW-1:W], div_busy};

  assign abs_a_c = a_i[W-1] ? -a_i : a_i;
  assign abs_b_c = b_i[W-1] ? -b_i : b_i;

  fxp_div_iter #(.WN(QW), .WD(W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_c),
    .dividend_i ({abs_a_c, {FW{1'b0}}}),
    .divisor_i  (abs_b_c),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    div_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d  = a_i;
          b_d  = b_i;
          op_d = aluop_i;
          dz_d = 1'b0;
          case (aluop_i)
            OP_ADD: begin
              result_d = add_s.val[W-1:0];
              ovf_d    = add_s.ovf;
              state_d  = ST_DONE;
            end
            OP_SUB: begin
              result_d = sub_s.val[W-1:0];
              ovf_d    = sub_s.ovf;
              state_d  = ST_DONE;
            end
            OP_MUL: state_d = ST_EXEC;
            default: begin
              if (b_i == '0) begin
                result_d = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                ovf_d    = 1'b0;
                dz_d     = 1'b1;
                state_d  = ST_DONE;
              end else begin
                div_start_c = 1'b1;
                state_d     = ST_EXEC;
              end
            end
          endcase
        end
      end
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          result_d = mul_s.val[W-1:0];
          ovf_d    = mul_s.ovf;
          state_d  = ST_DONE;
        end else if (div_done) begin
          result_d = div_s.val[W-1:0];
          ovf_d    = div_s.ovf;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE) && !rst;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign ovf_o       = ovf_q;
  assign dz_o        = dz_q;

endmodule

// File: tb/tb_fxp_alu.sv
// Directed bench for fxp_alu: integer-arithmetic reference model checked every output cycle.
module tb_fxp_alu;
  import fxp_pkg::*;

  localparam int unsigned W  = 24;
  localparam int unsigned FW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   aluop = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         ovf, dz;

  always #5 clk = ~clk;

  fxp_alu dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .aluop_i    (aluop),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .ovf_o      (ovf),
    .dz_o       (dz)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic         ovf;
    logic         dz;
    int           lat;
    int           stall;
  } vec_t;

  vec_t vecs[$];
  vec_t tv;

  int total = 0;
  int bad   = 0;

  // Reference: exact integer arithmetic, then clamp to the W-bit range.
  function automatic void model(input logic [W-1:0] ma_in, input logic [W-1:0] mb_in,
                                input logic [1:0] op, output logic [W-1:0] r,
                                output logic o, output logic d);
    longint sa, sb, v, hi, lo, ma, mb;
    sa = longint'($signed(ma_in));
    sb = longint'($signed(mb_in));
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -hi - 1;
    d  = 1'b0;
    case (op)
      2'b00: v = sa + sb;
      2'b01: v = sa - sb;
      2'b10: v = (sa * sb) >>> FW;
      default: begin
        if (sb == 0) begin
          d = 1'b1;
          v = (sa < 0) ? lo : hi;
        end else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          v  = (ma << FW) / mb;
          if ((sa < 0) != (sb < 0)) v = -v;
        end
      end
    endcase
    o = (v > hi) || (v < lo);
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    r = W'(v);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  bit           live = 1'b0, seen = 1'b0, post_hs = 1'b0;
  int           cnt = 0, e_lat = 0;
  logic [W-1:0] e_res;
  logic         e_ovf, e_dz;

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      live    = 1'b0;
      post_hs = 1'b0;
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_in_ready", W'(in_ready), '0);
      chk("rst_result", result, '0);
      chk("rst_flags", W'({ovf, dz}), '0);
    end else begin
      if (post_hs) begin
        chk("in_ready_after_hs", W'(in_ready), W'(1));
        post_hs = 1'b0;
      end
      if (live) begin
        cnt++;
        chk("in_ready_busy", W'(in_ready), '0);
        if (out_valid) begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", W'(cnt), W'(e_lat));
          end
          chk("result", result, e_res);
          chk("ovf", W'(ovf), W'(e_ovf));
          chk("dz", W'(dz), W'(e_dz));
          if (out_ready) begin
            live    = 1'b0;
            post_hs = 1'b1;
          end
        end else if (!seen && cnt > e_lat) begin
          total++;
          bad++;
          $display("FAIL timeout: no out_valid after %0d cycles, want %0d", cnt, e_lat);
          live = 1'b0;
        end
      end else begin
        chk("spurious_out_valid", W'(out_valid), '0);
        if (in_valid) begin
          chk("in_ready_idle", W'(in_ready), W'(1));
          if (in_ready) begin
            model(a, b, aluop, e_res, e_ovf, e_dz);
            chk("model_res", e_res, tv.res);
            chk("model_ovf", W'(e_ovf), W'(tv.ovf));
            chk("model_dz", W'(e_dz), W'(tv.dz));
            e_lat = tv.lat;
            cnt   = 0;
            seen  = 1'b0;
            live  = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    bit acc;
    @(posedge clk); #2;
    tv        = v;
    a         = v.a;
    b         = v.b;
    aluop     = v.op;
    in_valid  = 1'b1;
    out_ready = (v.stall == 0);
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    aluop    = 2'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    if (v.stall > 0) begin
      for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
      repeat (v.stall) @(negedge clk);
      @(posedge clk); #2;
      out_ready = 1'b1;
    end
    for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          a           b           op      res         ovf   dz    lat stall
    vecs.push_back('{24'h010000, 24'h008000, OP_ADD, 24'h018000, 1'b0, 1'b0, 1,  0});
    vecs.push_back('{24'h010000, 24'h008000, OP_SUB, 24'h008000, 1'b0, 1'b0, 1,  0});
    vecs.push_back('{24'h010000, 24'h008000, OP_MUL, 24'h008000, 1'b0, 1'b0, 2,  0});
    vecs.push_back('{24'hFE8000, 24'h020000, OP_MUL, 24'hFD0000, 1'b0, 1'b0, 2,  0});
    vecs.push_back('{24'h010000, 24'h008000, OP_DIV, 24'h020000, 1'b0, 1'b0, 41, 0});
    vecs.push_back('{24'h010000, 24'h000000, OP_DIV, 24'h7FFFFF, 1'b0, 1'b1, 1,  0});
    vecs.push_back('{24'hFF0000, 24'h000000, OP_DIV, 24'h800000, 1'b0, 1'b1, 1,  0});
    vecs.push_back('{24'h640000, 24'h640000, OP_ADD, 24'h7FFFFF, 1'b1, 1'b0, 1,  0});
    vecs.push_back('{24'h9C0000, 24'h640000, OP_MUL, 24'h800000, 1'b1, 1'b0, 2,  0});
    vecs.push_back('{24'h800000, 24'h010000, OP_SUB, 24'h800000, 1'b1, 1'b0, 1,  0});
    vecs.push_back('{24'h7FFFFF, 24'h000001, OP_DIV, 24'h7FFFFF, 1'b1, 1'b0, 41, 0});
    vecs.push_back('{24'hFF0000, 24'h030000, OP_DIV, 24'hFFAAAB, 1'b0, 1'b0, 41, 0});
    vecs.push_back('{24'hFFFFFF, 24'h008000, OP_MUL, 24'hFFFFFF, 1'b0, 1'b0, 2,  0});
    vecs.push_back('{24'h800000, 24'hFF0000, OP_DIV, 24'h7FFFFF, 1'b1, 1'b0, 41, 0});
    vecs.push_back('{24'h800000, 24'h010000, OP_DIV, 24'h800000, 1'b0, 1'b0, 41, 0});
    vecs.push_back('{24'h000001, 24'h000002, OP_ADD, 24'h000003, 1'b0, 1'b0, 1,  10});
    vecs.push_back('{24'hFE8000, 24'h020000, OP_MUL, 24'hFD0000, 1'b0, 1'b0, 2,  10});

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort a divide part-way; the discarded result must never appear.
    issue(vecs[4]);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (45) @(posedge clk);
    run_vec('{24'h020000, 24'hFF0000, OP_ADD, 24'h010000, 1'b0, 1'b0, 1, 0});

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fxp_alu.md
# fxp_alu

Parametrised, handshaked fixed-point ALU for signed Q(IW).(FW) operands: add, subtract, multiply and divide with saturation and status flags. It replaces the combinational Q8.16 ALU in the image-processing datapath. A single-outstanding-operation valid/ready wrapper lets a multi-cycle iterative divider and a registered multiplier close timing. The defaults reproduce Q8.16 numerics, with saturation replacing wrap-around.

## Interface
- IW, 8, integer bits, sign included
- FW, 16, fraction bits
- W (derived, not overridable), IW+FW, word width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block idle and able to accept
- a  in  W  signed operand A, Q(IW).(FW)
- b  in  W  signed operand B, Q(IW).(FW)
- aluop  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  W  signed result, Q(IW).(FW)
- ovf  out  1  result was saturated
- dz  out  1  division by zero

## Operation
- States: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) && !rst.
- Accept on in_valid && in_ready. a, b and aluop are registered at accept and ignored afterwards.
- ADD/SUB: W+1-bit exact sum, then saturate. Go IDLE->DONE.
- MUL: 2W-bit product, then arithmetic shift right by FW (truncation toward -inf), then saturate. One EXEC cycle.
- DIV, b!=0:
  - Restoring division of |a|<<FW by |b|, one quotient bit per cycle, W+FW cycles in EXEC.
  - Quotient truncates toward zero; sign applied as sign(a) XOR sign(b); then saturate.
  - ovf=1 if the magnitude exceeds the representable range.
- DIV, b==0: no iteration, go IDLE->DONE.
  - result = 2^(W-1)-1 if a>=0, else -2^(W-1).
  - dz=1, ovf=0.
- Saturation bounds: max 2^(W-1)-1, min -2^(W-1). ovf=1 exactly when clamping occurred.
- DONE: out_valid=1. result, ovf and dz stay stable until out_valid && out_ready, then return to IDLE. in_ready is high the following cycle; there is no same-cycle re-accept.
- aluop is a 2-bit field, so every encoding is defined.

## Timing
- Reset values: state=IDLE, out_valid=0, result=0, ovf=0, dz=0, in_ready=0 while rst is high.
- Latency from the accept edge to out_valid high:
  - add/sub: 1 cycle
  - mul: 2 cycles
  - div by zero: 1 cycle
  - div: W+FW+1 cycles (41 for defaults)
- Throughput: one operation per latency+1 cycles when out_ready is held high.
- A reset asserted during EXEC or DONE aborts the operation immediately and asynchronously. The result is discarded and never presented.
- A consumer holding out_ready low stalls the block indefinitely with no loss or change of the result.
- in_valid asserted while in_ready=0 is ignored. The producer must hold it.

## Structure
- Package fxp_pkg:
  - aluop constants OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - state enum
  - function sat(value, W) returning the clamped value and its ovf bit
- Sub-module fxp_div_iter: parametrised restoring divider with start/busy/done, the quotient-bit counter, and remainder/quotient registers. Instantiated once.
- The top level holds the FSM, operand registers, add/sub/mul datapath and output registers.

## Test plan
Defaults: 1.0=0x010000, 0.5=0x008000.
- add 1.0+0.5 -> 0x018000, ovf=0, out_valid 1 cycle after accept. sub 1.0-0.5 -> 0x008000.
- mul 1.0*0.5 -> 0x008000 at 2 cycles. mul -1.5*2.0 (0xFE8000, 0x020000) -> 0xFD0000.
- div 1.0/0.5 -> 0x020000, out_valid exactly 41 cycles after accept, in_ready low throughout.
- div 1.0/0 -> 0x7FFFFF, dz=1, 1 cycle. div -1.0/0 -> 0x800000, dz=1.
- add 100.0+100.0 (0x640000 twice) -> 0x7FFFFF, ovf=1. mul -100.0*100.0 -> 0x800000, ovf=1.
- Hold out_ready low for 10 cycles after a result, then check the result is stable and in_ready stays low. Separately, assert rst mid-divide, then check out_valid=0 and a fresh add completes correctly after release.
